// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: eight gate functions on two WIDTH-bit operands,
// valid/ready on both sides. Define LU_STATS_EN to add the txn_count port.
`timescale 1ns/1ps
module logic_unit_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_zero,
    output logic             flag_par
`ifdef LU_STATS_EN
    ,
    output logic [15:0]      txn_count
`endif
);

    // Each stage carries {parity, zero, data}.
    localparam int DW = WIDTH + 2;

    if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
        $error("logic_unit_pipe: WIDTH must be 1..64");
    end
    if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
        $error("logic_unit_pipe: STAGES must be 1..4");
    end

    logic [WIDTH-1:0] w_func;
    logic [DW-1:0]    w_d_chain [STAGES+1];
    logic [STAGES:0]  w_v_chain;
    logic [STAGES:0]  w_ready;

    always_comb begin
        w_func = '0;
        case (op)
            3'd0:    w_func = a & b;
            3'd1:    w_func = a | b;
            3'd2:    w_func = ~(a & b);
            3'd3:    w_func = ~(a | b);
            3'd4:    w_func = a ^ b;
            3'd5:    w_func = ~(a ^ b);
            3'd6:    w_func = ~a;
            default: w_func = ~b;
        endcase
    end

    assign w_v_chain[0] = in_valid;
    assign w_d_chain[0] = {^w_func, ~|w_func, w_func};

    // A stage may load when it is empty or its successor takes its beat this cycle.
    always_comb begin
        w_ready         = '0;
        w_ready[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            w_ready[k] = ~w_v_chain[k+1] | w_ready[k+1];
        end
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
        logic          r_v;
        logic [DW-1:0] r_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_v <= 1'b0;
                r_d <= '0;
            end else if (w_ready[gi]) begin
                r_v <= w_v_chain[gi];
                if (w_v_chain[gi]) begin
                    r_d <= w_d_chain[gi];
                end
            end
        end

        assign w_v_chain[gi+1] = r_v;
        assign w_d_chain[gi+1] = r_d;
    end

    assign in_ready  = rst_n & w_ready[0];
    assign out_valid = w_v_chain[STAGES];
    assign result    = w_d_chain[STAGES][WIDTH-1:0];
    assign flag_zero = w_d_chain[STAGES][WIDTH];
    assign flag_par  = w_d_chain[STAGES][WIDTH+1];

`ifdef LU_STATS_EN
    logic [15:0] r_txn_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_txn_count <= 16'd0;
        end else if (out_valid && out_ready) begin
            r_txn_count <= r_txn_count + 16'd1;
        end
    end

    assign txn_count = r_txn_count;
`endif

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed tables, backpressure, reset,
// random traffic against a truth-table reference model, and a depth sweep.
`timescale 1ns/1ps
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] result;
    logic       flag_zero;
    logic       flag_par;
`ifdef LU_STATS_EN
    logic [15:0] txn_count;
    logic [15:0] exp_txn;
`endif

    // Depth-sweep instances share op/a/b but have their own handshakes.
    logic       sw_valid;
    logic       sw_ready;
    logic       s1_in_ready, s1_out_valid, s1_zero, s1_par;
    logic       s4_in_ready, s4_out_valid, s4_zero, s4_par;
    logic [7:0] s1_result, s4_result;
`ifdef LU_STATS_EN
    logic [15:0] s1_txn, s4_txn;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .STAGES(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flag_zero(flag_zero), .flag_par(flag_par)
`ifdef LU_STATS_EN
        , .txn_count(txn_count)
`endif
    );

    logic_unit_pipe #(.WIDTH(8), .STAGES(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s1_in_ready),
        .op(op), .a(a), .b(b), .out_valid(s1_out_valid), .out_ready(sw_ready),
        .result(s1_result), .flag_zero(s1_zero), .flag_par(s1_par)
`ifdef LU_STATS_EN
        , .txn_count(s1_txn)
`endif
    );

    logic_unit_pipe #(.WIDTH(8), .STAGES(4)) u_s4 (
        .clk(clk), .rst_n(rst_n), .in_valid(sw_valid), .in_ready(s4_in_ready),
        .op(op), .a(a), .b(b), .out_valid(s4_out_valid), .out_ready(sw_ready),
        .result(s4_result), .flag_zero(s4_zero), .flag_par(s4_par)
`ifdef LU_STATS_EN
        , .txn_count(s4_txn)
`endif
    );

    // Reference: per-bit truth table indexed by {a_bit, b_bit}.
    logic [3:0] tt [8];

    function automatic logic [7:0] ref_fn(input logic [2:0] o, input logic [7:0] x, input logic [7:0] y);
        logic [7:0] r;
        logic [3:0] t;
        t = tt[o];
        for (int i = 0; i < 8; i++) r[i] = t[{x[i], y[i]}];
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    logic [7:0] model_q [$];
    logic       prev_stall = 1'b0;
    logic [7:0] prev_res;

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall = 1'b0;
`ifdef LU_STATS_EN
            exp_txn = 16'd0;
`endif
        end else begin
            logic [7:0] e;
            if (prev_stall) begin
                chk("hold_valid", {31'd0, out_valid}, 32'd1);
                chk("hold_data", {24'd0, result}, {24'd0, prev_res});
            end
`ifdef LU_STATS_EN
            chk("txn_count", {16'd0, txn_count}, {16'd0, exp_txn});
`endif
            if (in_valid && in_ready) model_q.push_back(ref_fn(op, a, b));
            if (out_valid && out_ready) begin
`ifdef LU_STATS_EN
                exp_txn = exp_txn + 16'd1;
`endif
                if (model_q.size() == 0) begin
                    chk("spurious_out", {24'd0, result}, 32'hFFFF_FFFF);
                end else begin
                    e = model_q.pop_front();
                    chk("sb_result", {24'd0, result}, {24'd0, e});
                    chk("sb_zero", {31'd0, flag_zero}, {31'd0, (e == 8'd0)});
                    chk("sb_par", {31'd0, flag_par}, {31'd0, ($countones(e) % 2 == 1)});
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = result;
        end
    end

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic       z;
        logic       p;
    } vec_t;

    vec_t tbl [10];

    initial begin
        #5_000_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int lat1, lat4, cnt1, cnt4;
        logic [7:0] bp_a [6];
        logic [7:0] bp_b [6];
        logic [2:0] bp_op [6];

        tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0111; tt[3] = 4'b0001;
        tt[4] = 4'b0110; tt[5] = 4'b1001; tt[6] = 4'b0011; tt[7] = 4'b0101;

        tbl[0] = '{3'd0, 8'hA5, 8'hC3, 8'h81, 1'b0, 1'b0};
        tbl[1] = '{3'd1, 8'hA5, 8'hC3, 8'hE7, 1'b0, 1'b0};
        tbl[2] = '{3'd2, 8'hA5, 8'hC3, 8'h7E, 1'b0, 1'b0};
        tbl[3] = '{3'd3, 8'hA5, 8'hC3, 8'h18, 1'b0, 1'b0};
        tbl[4] = '{3'd4, 8'hA5, 8'hC3, 8'h66, 1'b0, 1'b0};
        tbl[5] = '{3'd5, 8'hA5, 8'hC3, 8'h99, 1'b0, 1'b0};
        tbl[6] = '{3'd6, 8'hA5, 8'hC3, 8'h5A, 1'b0, 1'b0};
        tbl[7] = '{3'd7, 8'hA5, 8'hC3, 8'h3C, 1'b0, 1'b0};
        tbl[8] = '{3'd4, 8'h55, 8'h55, 8'h00, 1'b1, 1'b0};
        tbl[9] = '{3'd0, 8'hFF, 8'h07, 8'h07, 1'b0, 1'b1};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
        sw_valid = 1'b0; sw_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_result", {24'd0, result}, 32'd0);
        chk("rst_flags", {30'd0, flag_par, flag_zero}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Directed table: one beat per cycle, result exactly 2 cycles later
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (c < 10) begin
                in_valid = 1'b1; op = tbl[c].op; a = tbl[c].a; b = tbl[c].b;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 10) chk("tbl_in_ready", {31'd0, in_ready}, 32'd1);
            if (c >= 2) begin
                chk("tbl_valid", {31'd0, out_valid}, 32'd1);
                chk("tbl_result", {24'd0, result}, {24'd0, tbl[c-2].res});
                chk("tbl_flags", {30'd0, flag_par, flag_zero}, {30'd0, tbl[c-2].p, tbl[c-2].z});
            end
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (3) @(negedge clk);

        // Backpressure: 6 beats, out_ready low for 5 cycles
        for (int i = 0; i < 6; i++) begin
            bp_a[i] = 8'($urandom); bp_b[i] = 8'($urandom); bp_op[i] = 3'($urandom);
        end
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op = bp_op[idx]; a = bp_a[idx]; b = bp_b[idx];
            @(negedge clk);
            if (in_ready) idx++;
        end
        chk("bp_accepts", idx, 2);
        chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
        out_ready = 1'b1;
        for (int c = 0; c < 50 && idx < 6; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op = bp_op[idx]; a = bp_a[idx]; b = bp_b[idx];
            @(negedge clk);
            if (in_ready) idx++;
        end
        chk("bp_all_accepted", idx, 6);
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("bp_drained", model_q.size(), 0);

        // Reset with two beats in flight
        out_ready = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op = 3'd1; a = 8'h0F; b = 8'hF0;
        end
        @(posedge clk); #3 rst_n = 1'b0;
        model_q.delete();
        #1;
        chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_result", {24'd0, result}, 32'd0);
        chk("mid_rst_flags", {30'd0, flag_par, flag_zero}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, in_ready}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", {31'd0, in_ready}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            chk("no_stale_beat", {31'd0, out_valid}, 32'd0);
        end

        // Random traffic against the scoreboard
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
        end
        @(posedge clk); #1 in_valid = 1'b0; out_ready = 1'b1;
        repeat (6) @(negedge clk);
        chk("rand_drained", model_q.size(), 0);

        // Depth sweep: latency of a single beat
        lat1 = -1; lat4 = -1;
        @(posedge clk); #1 sw_valid = 1'b1; op = 3'd4; a = 8'h3C; b = 8'h0F;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (s1_out_valid && lat1 < 0) lat1 = k;
            if (s4_out_valid && lat4 < 0) lat4 = k;
            @(posedge clk); #1 sw_valid = 1'b0;
        end
        chk("s1_latency", lat1, 1);
        chk("s4_latency", lat4, 4);
        chk("s1_result", {24'd0, s1_result}, {24'd0, ref_fn(3'd4, 8'h3C, 8'h0F)});

        // Continuous stream of 12 beats -> 12 consecutive results
        cnt1 = 0; cnt4 = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1 sw_valid = (k < 12);
            @(negedge clk);
            if (s1_out_valid && k >= 1 && k < 13) cnt1++;
            if (s4_out_valid && k >= 4 && k < 16) cnt4++;
        end
        chk("s1_stream", cnt1, 12);
        chk("s4_stream", cnt4, 12);

`ifdef LU_STATS_EN
        // Counter wrap and stall behaviour
        @(posedge clk); #3 rst_n = 1'b0;
        model_q.delete();
        @(posedge clk); #1 rst_n = 1'b1; out_ready = 1'b1;
        for (int c = 0; c < 65538; c++) begin
            @(posedge clk); #1;
            in_valid = 1'b1; op = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
        end
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("txn_wrap", {16'd0, txn_count}, 32'd2);
        out_ready = 1'b0;
        @(posedge clk); #1 in_valid = 1'b1;
        @(posedge clk); #1 in_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("txn_stalled", {16'd0, txn_count}, 32'd2);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("txn_after_stall", {16'd0, txn_count}, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
